// File: rtl/spike_axis_packer.sv
// -----------------------------------------------------------------------------
// spike_axis_packer
//
// Purpose:
//   Transmit-side bridge from the SNN core's spike-output handshake to a 32-bit
//   AXI4-Stream master. Output spike events are buffered in a small FIFO. Each
//   event is stamped with the current timestep. Every timestep is closed by a
//   marker word that carries TLAST and the number of spikes in that timestep.
//
// Word formats (bit 32 of a FIFO entry is TLAST):
//   spike  : {1'b0, ts[12:0], weight[7:0], neuron_id[9:0]}, TLAST = 0
//   marker : {1'b1, ts[12:0], step_cnt[17:0]},               TLAST = 1
//
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   enable                   accept spikes/ticks when high; the FIFO drains
//                            regardless
//   sync_clear               one-cycle synchronous clear of FIFO, counters, flags
//   timestep_tick            one-cycle pulse that ends the current timestep
//   spike_out_valid/_ready   core spike handshake
//   spike_out_neuron_id      firing neuron id (10 bits)
//   spike_out_weight         event payload (8 bits)
//   m_axis_spikes_*          AXI4-Stream master (TKEEP is tied to 4'hF)
//   fifo_level               current FIFO occupancy, 0..FIFO_DEPTH
//   tick_overrun             sticky: a tick arrived while a marker was pending
//   total_spikes             spikes accepted since reset/clear, wraps
//
// The word layout places ts at bits [30:18]. It therefore assumes
// TS_WIDTH = 13 and CNT_WIDTH = 18, which together with the marker flag bit
// fill exactly 32 bits.
// -----------------------------------------------------------------------------
module spike_axis_packer #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int TS_WIDTH   = 13,
  parameter  int CNT_WIDTH  = 18,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = AW + 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             enable,
  input  logic             sync_clear,
  input  logic             timestep_tick,
  input  logic             spike_out_valid,
  input  logic [9:0]       spike_out_neuron_id,
  input  logic [7:0]       spike_out_weight,
  output logic             spike_out_ready,
  output logic [31:0]      m_axis_spikes_TDATA,
  output logic             m_axis_spikes_TVALID,
  input  logic             m_axis_spikes_TREADY,
  output logic             m_axis_spikes_TLAST,
  output logic [3:0]       m_axis_spikes_TKEEP,
  output logic [LVL_W-1:0] fifo_level,
  output logic             tick_overrun,
  output logic [31:0]      total_spikes
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [32:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic                 marker_pending_q, marker_pending_d;
  logic                 tick_overrun_q, tick_overrun_d;
  logic [31:0]          total_q, total_d;

  // ---------------------------------------------------------------------------
  // Handshake and push/pop decisions (all from registered state)
  // ---------------------------------------------------------------------------
  logic        fifo_full;
  logic        fifo_empty;
  logic        spike_acc;
  logic        marker_push;
  logic        push;
  logic        pop;
  logic [32:0] push_word;
  logic [32:0] head_word;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // Fullness is the pre-pop value, so a pop on a full FIFO never enables a
  // push in the same cycle.
  assign spike_out_ready = enable & ~marker_pending_q & ~fifo_full & ~sync_clear;
  assign spike_acc       = spike_out_valid & spike_out_ready;

  // A pending marker blocks spike acceptance, so spike_acc and marker_push
  // can never both be high. The marker goes out even when enable is low.
  assign marker_push = marker_pending_q & ~fifo_full & ~sync_clear;
  assign push        = spike_acc | marker_push;

  // FWFT: a word becomes visible the cycle after its push, so a pop on an
  // empty FIFO cannot happen.
  assign pop = ~fifo_empty & m_axis_spikes_TREADY & ~sync_clear;

  always_comb begin
    push_word = '0;
    if (marker_push) begin
      push_word[32]                = 1'b1;
      push_word[31]                = 1'b1;
      push_word[30 -: TS_WIDTH]    = ts_q;
      push_word[CNT_WIDTH-1:0]     = step_cnt_q;
    end else begin
      push_word[30 -: TS_WIDTH]    = ts_q;
      push_word[17:10]             = spike_out_weight;
      push_word[9:0]               = spike_out_neuron_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    level_d          = level_q;
    ts_d             = ts_q;
    step_cnt_d       = step_cnt_q;
    marker_pending_d = marker_pending_q;
    tick_overrun_d   = tick_overrun_q;
    total_d          = total_q;

    if (sync_clear) begin
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      level_d          = '0;
      ts_d             = '0;
      step_cnt_d       = '0;
      marker_pending_d = 1'b0;
      tick_overrun_d   = 1'b0;
      total_d          = '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);

      if (spike_acc) begin
        total_d = total_q + 32'd1;
        if (step_cnt_q != '1) begin
          step_cnt_d = step_cnt_q + CNT_WIDTH'(1);
        end
      end

      // The marker carries the step_cnt/ts values of the timestep it closes.
      if (marker_push) begin
        marker_pending_d = 1'b0;
        ts_d             = ts_q + TS_WIDTH'(1);
        step_cnt_d       = '0;
      end

      // Tick handling looks at the registered pending flag. A tick in the same
      // cycle a marker leaves is still an overrun, because that marker belongs
      // to the previous tick. A spike accepted alongside a tick was counted
      // above and therefore lands in this timestep's marker.
      if (timestep_tick && enable) begin
        if (marker_pending_q) begin
          tick_overrun_d = 1'b1;
        end else begin
          marker_pending_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
      ts_q             <= '0;
      step_cnt_q       <= '0;
      marker_pending_q <= 1'b0;
      tick_overrun_q   <= 1'b0;
      total_q          <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      level_q          <= level_d;
      ts_q             <= ts_d;
      step_cnt_q       <= step_cnt_d;
      marker_pending_q <= marker_pending_d;
      tick_overrun_q   <= tick_overrun_d;
      total_q          <= total_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. This is data only; validity is tracked by level_q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (push && !sync_clear) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream outputs. The head entry is read straight from storage. It holds
  // steady under back-pressure because rd_ptr_q only moves on a pop. TDATA
  // and TLAST are forced to zero while nothing is valid.
  // ---------------------------------------------------------------------------
  assign head_word            = mem_q[rd_ptr_q];
  assign m_axis_spikes_TVALID = ~fifo_empty;
  assign m_axis_spikes_TDATA  = fifo_empty ? 32'd0 : head_word[31:0];
  assign m_axis_spikes_TLAST  = fifo_empty ? 1'b0  : head_word[32];
  assign m_axis_spikes_TKEEP  = 4'hF;

  assign fifo_level   = level_q;
  assign tick_overrun = tick_overrun_q;
  assign total_spikes = total_q;

endmodule

// File: tb/tb_spike_axis_packer.sv
module tb_spike_axis_packer;

  localparam int DEPTH = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sync_clear = 1'b0;
  logic        timestep_tick = 1'b0;
  logic        spike_out_valid = 1'b0;
  logic [9:0]  spike_out_neuron_id = '0;
  logic [7:0]  spike_out_weight = '0;
  logic        spike_out_ready;
  logic [31:0] m_axis_spikes_TDATA;
  logic        m_axis_spikes_TVALID;
  logic        m_axis_spikes_TREADY = 1'b0;
  logic        m_axis_spikes_TLAST;
  logic [3:0]  m_axis_spikes_TKEEP;
  logic [4:0]  fifo_level;
  logic        tick_overrun;
  logic [31:0] total_spikes;

  spike_axis_packer dut (
    .ap_clk               (ap_clk),
    .ap_rst_n             (ap_rst_n),
    .enable               (enable),
    .sync_clear           (sync_clear),
    .timestep_tick        (timestep_tick),
    .spike_out_valid      (spike_out_valid),
    .spike_out_neuron_id  (spike_out_neuron_id),
    .spike_out_weight     (spike_out_weight),
    .spike_out_ready      (spike_out_ready),
    .m_axis_spikes_TDATA  (m_axis_spikes_TDATA),
    .m_axis_spikes_TVALID (m_axis_spikes_TVALID),
    .m_axis_spikes_TREADY (m_axis_spikes_TREADY),
    .m_axis_spikes_TLAST  (m_axis_spikes_TLAST),
    .m_axis_spikes_TKEEP  (m_axis_spikes_TKEEP),
    .fifo_level           (fifo_level),
    .tick_overrun         (tick_overrun),
    .total_spikes         (total_spikes)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stream contents as an ordered list of 33-bit words
  // {tlast, tdata}, plus timestep bookkeeping.
  logic [32:0] m_q[$];
  logic [12:0] m_ts;
  logic [17:0] m_cnt;
  logic        m_pend;
  logic        m_ovr;
  logic [31:0] m_total;

  // Every word handed over on the stream, as seen at the DUT pins.
  logic [32:0] obs[$];
  logic        last_acc;
  logic        last_ready;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ts    = '0;
    m_cnt   = '0;
    m_pend  = 1'b0;
    m_ovr   = 1'b0;
    m_total = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the effect of the coming rising edge.
  task automatic step(input logic en, input logic sc, input logic tk, input logic vld,
                      input logic [9:0] id, input logic [7:0] w, input logic rdy);
    logic full;
    logic exp_ready;
    logic pend_old;
    @(negedge ap_clk);
    enable               = en;
    sync_clear           = sc;
    timestep_tick        = tk;
    spike_out_valid      = vld;
    spike_out_neuron_id  = id;
    spike_out_weight     = w;
    m_axis_spikes_TREADY = rdy;
    #1;
    full      = (m_q.size() == DEPTH);
    exp_ready = en & ~m_pend & ~full & ~sc;
    check_val("ready", spike_out_ready, exp_ready);
    check_val("tvalid", m_axis_spikes_TVALID, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check_val("tdata", m_axis_spikes_TDATA, m_q[0][31:0]);
      check_val("tlast", m_axis_spikes_TLAST, m_q[0][32]);
    end
    check_val("level", fifo_level, m_q.size());
    check_val("overrun", tick_overrun, m_ovr);
    check_val("total", total_spikes, m_total);
    last_ready = spike_out_ready;
    last_acc   = exp_ready & vld;
    if (m_axis_spikes_TVALID && rdy && !sc) obs.push_back({m_axis_spikes_TLAST, m_axis_spikes_TDATA});

    if (sc) begin
      model_clear();
    end else begin
      pend_old = m_pend;
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (exp_ready && vld) begin
        m_q.push_back({1'b0, 1'b0, m_ts, w, id});
        m_total = m_total + 1;
        if (m_cnt != 18'h3FFFF) m_cnt = m_cnt + 1;
      end else if (pend_old && !full) begin
        m_q.push_back({1'b1, 1'b1, m_ts, m_cnt});
        m_ts   = m_ts + 1;
        m_cnt  = '0;
        m_pend = 1'b0;
      end
      if (tk && en) begin
        if (pend_old) m_ovr = 1'b1;
        else          m_pend = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0, rdy);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n             = 1'b0;
    enable               = 1'b0;
    sync_clear           = 1'b0;
    timestep_tick        = 1'b0;
    spike_out_valid      = 1'b0;
    m_axis_spikes_TREADY = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    model_clear();
    check_val("rst_tvalid", m_axis_spikes_TVALID, 0);
    check_val("rst_tlast", m_axis_spikes_TLAST, 0);
    check_val("rst_tdata", m_axis_spikes_TDATA, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_ready", spike_out_ready, 0);
    check_val("rst_total", total_spikes, 0);
    check_val("rst_ovr", tick_overrun, 0);
    check_val("tkeep", m_axis_spikes_TKEEP, 4'hF);
    ap_rst_n = 1'b1;
    obs.delete();
  endtask

  initial begin
    int acc_cnt;
    int n_mark;
    int errs;
    logic [32:0] w;

    // Basic packing: three spikes, a tick, then a spike in the next timestep.
    do_reset();
    step(1, 0, 0, 1, 10'd5,    8'h10, 1);
    step(1, 0, 0, 1, 10'd1023, 8'hFF, 1);
    step(1, 0, 0, 1, 10'd0,    8'h01, 1);
    step(1, 0, 1, 0, 10'd0,    8'h00, 1);
    repeat (4) idle(1);
    step(1, 0, 0, 1, 10'd7, 8'h00, 1);
    repeat (3) idle(1);
    check_val("s1_count", obs.size(), 5);
    check_val("s1_w0", obs[0], 33'h0_00004005);
    check_val("s1_w1", obs[1], 33'h0_0003FFFF);
    check_val("s1_w2", obs[2], 33'h0_00000400);
    check_val("s1_mark", obs[3], 33'h1_80000003);
    w = obs[4];
    check_val("s1_next_ts", w[30:18], 13'd1);

    // Back-pressure: exactly DEPTH accepted, then an in-order drain.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 0, 1, 10'($urandom), 8'($urandom), 0);
      if (last_acc) acc_cnt++;
    end
    check_val("s2_acc", acc_cnt, DEPTH);
    check_val("s2_level", fifo_level, DEPTH);
    check_val("s2_ready", spike_out_ready, 0);
    repeat (DEPTH + 4) idle(1);
    check_val("s2_drained", obs.size(), DEPTH);
    check_val("s2_ready_back", spike_out_ready, 1);

    // Spike in the same cycle as the tick is counted in that timestep.
    do_reset();
    step(1, 0, 1, 1, 10'd3, 8'h22, 1);
    step(1, 0, 0, 1, 10'd4, 8'h33, 1);
    check_val("s3_ready_blocked", last_ready, 0);
    repeat (4) idle(1);
    check_val("s3_count", obs.size(), 2);
    check_val("s3_mark", obs[1], 33'h1_80000001);

    // Overrun: FIFO full, tick pending, second tick dropped.
    do_reset();
    repeat (DEPTH) step(1, 0, 0, 1, 10'($urandom), 8'($urandom), 0);
    step(1, 0, 1, 0, 10'd0, 8'd0, 0);
    step(1, 0, 1, 0, 10'd0, 8'd0, 0);
    idle(0);
    check_val("s4_overrun", tick_overrun, 1);
    repeat (DEPTH + 6) idle(1);
    n_mark = 0;
    foreach (obs[i]) if (obs[i][32]) n_mark++;
    check_val("s4_markers", n_mark, 1);

    // Timestep wrap: 8192 empty timesteps.
    do_reset();
    for (int i = 0; i < 8192; i++) begin
      step(1, 0, 1, 0, 10'd0, 8'd0, 1);
      idle(1);
    end
    repeat (3) idle(1);
    check_val("s5_count", obs.size(), 8192);
    errs = 0;
    foreach (obs[i]) if (obs[i] !== {1'b1, 1'b1, 13'(i), 18'd0}) errs++;
    check_val("s5_marker_errs", errs, 0);
    step(1, 0, 0, 1, 10'd9, 8'd9, 1);
    repeat (3) idle(1);
    w = obs[obs.size() - 1];
    check_val("s5_wrap_ts", w[30:18], 13'd0);
    check_val("s5_wrap_last", w[32], 1'b0);

    // Asynchronous reset with a half-full FIFO.
    do_reset();
    repeat (8) step(1, 0, 0, 1, 10'($urandom), 8'($urandom), 0);
    idle(0);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check_val("s6_rst_tvalid", m_axis_spikes_TVALID, 0);
    check_val("s6_rst_level", fifo_level, 0);
    check_val("s6_rst_total", total_spikes, 0);
    model_clear();
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    // Synchronous clear with a half-full FIFO.
    repeat (8) step(1, 0, 0, 1, 10'($urandom), 8'($urandom), 0);
    step(1, 1, 0, 1, 10'd1, 8'd1, 1);
    idle(0);
    check_val("s6_clr_tvalid", m_axis_spikes_TVALID, 0);
    check_val("s6_clr_level", fifo_level, 0);
    check_val("s6_clr_total", total_spikes, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 249) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
           10'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
